// File: rtl/dtpu_out_fifo.sv
// Output FIFO between dtpu_core and the PS: show-ahead circular buffer drained
// over AXI-stream, with PKT_LEN-beat packet framing and a sticky overflow flag.
module dtpu_out_fifo #(
    parameter int DATA_WIDTH_FIFO_OUT = 64,
    parameter int DEPTH               = 16,
    parameter int PKT_LEN             = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           outfifo_write,
    input  logic [DATA_WIDTH_FIFO_OUT-1:0] outfifo_din,
    output logic                           outfifo_is_full,
    input  logic                           clear,
    output logic [DATA_WIDTH_FIFO_OUT-1:0] m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH_FIFO_OUT-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0]   beat_cnt;
    logic          wr_acc;
    logic          rd_acc;

    assign outfifo_is_full = (count == CW'(DEPTH));
    assign m_axis_tvalid   = (count != '0);
    assign m_axis_tdata    = mem[rd_ptr];
    assign m_axis_tlast    = m_axis_tvalid && (beat_cnt == 16'(PKT_LEN - 1));

    assign wr_acc = outfifo_write && !outfifo_is_full;
    assign rd_acc = m_axis_tvalid && m_axis_tready;

    // Storage is never cleared; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (!reset && !clear && wr_acc)
            mem[wr_ptr] <= outfifo_din;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            if (outfifo_write && outfifo_is_full)
                overflow <= 1'b1;
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (rd_acc)
                beat_cnt <= m_axis_tlast ? 16'd0 : beat_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_dtpu_out_fifo.sv
// Bench for dtpu_out_fifo: directed and random steps checked against a
// queue-based model of occupancy, data order, packet framing and overflow.
module tb_dtpu_out_fifo;
    localparam int DW      = 64;
    localparam int DEPTH   = 16;
    localparam int PKT_LEN = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          outfifo_write = 1'b0;
    logic [DW-1:0] outfifo_din = '0;
    logic          outfifo_is_full;
    logic          clear = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [4:0]    count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    int            beat = 0;
    bit            ovf  = 1'b0;

    dtpu_out_fifo #(.DATA_WIDTH_FIFO_OUT(DW), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
        .clk(clk),
        .reset(reset),
        .outfifo_write(outfifo_write),
        .outfifo_din(outfifo_din),
        .outfifo_is_full(outfifo_is_full),
        .clear(clear),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".tvalid"}, 64'(m_axis_tvalid), 64'(q.size() != 0));
        chk({tag, ".full"}, 64'(outfifo_is_full), 64'(q.size() == DEPTH));
        chk({tag, ".overflow"}, 64'(overflow), 64'(ovf));
        chk({tag, ".tlast"}, 64'(m_axis_tlast), 64'(q.size() != 0 && beat == PKT_LEN - 1));
        if (q.size() != 0)
            chk({tag, ".tdata"}, m_axis_tdata, q[0]);
    endtask

    // One clock: drive inputs, advance the model by the same rules, then compare.
    task automatic step(input string tag, input bit w, input logic [DW-1:0] d,
                        input bit r, input bit c, input bit rst);
        bit full;
        bit valid;
        reset = rst; clear = c; outfifo_write = w; outfifo_din = d; m_axis_tready = r;
        full  = (q.size() == DEPTH);
        valid = (q.size() != 0);
        if (rst || c) begin
            q.delete(); beat = 0; ovf = 1'b0;
        end else begin
            if (w && full) ovf = 1'b1;
            if (valid && r) begin
                void'(q.pop_front());
                beat = (beat + 1) % PKT_LEN;
            end
            if (w && !full) q.push_back(d);
        end
        @(posedge clk); #1;
        reset = 1'b0; clear = 1'b0; outfifo_write = 1'b0; m_axis_tready = 1'b0;
        compare_all(tag);
    endtask

    initial begin
        logic [DW-1:0] rd;
        bit w;
        // reset state
        step("reset", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step("reset2", 1'b0, '0, 1'b1, 1'b0, 1'b1);

        // single word, then empty read attempt
        step("single_wr", 1'b1, 64'h2020202020202020, 1'b0, 1'b0, 1'b0);
        chk("single_data", m_axis_tdata, 64'h2020202020202020);
        step("single_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("single_empty_cnt", 64'(count), 64'd0);
        step("empty_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // fill to 17 with no drain: last write dropped
        for (int i = 1; i <= 17; i++)
            step("fill", 1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_overflow", 64'(overflow), 64'd1);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_order", m_axis_tdata, 64'(i));
            step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        end

        // full with simultaneous read and write: write dropped
        step("clr0", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++)
            step("refill", 1'b1, 64'(100 + i), 1'b0, 1'b0, 1'b0);
        step("full_rw", 1'b1, 64'hAA, 1'b1, 1'b0, 1'b0);
        chk("full_rw_cnt", 64'(count), 64'd15);
        step("clr1", 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // packet framing across 20 streamed words, then clear restarts framing
        for (int i = 0; i < 20; i++)
            step("frame", 1'b1, 64'(200 + i), 1'b1, 1'b0, 1'b0);
        step("frame_tail", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("frame_clr", 1'b1, 64'h55, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            step("frame2", 1'b1, 64'(300 + i), 1'b1, 1'b0, 1'b0);

        // random wrap-around traffic; occasional writes while full exercise drops
        for (int i = 0; i < 120; i++) begin
            rd = {$urandom, $urandom};
            w  = (q.size() < DEPTH) ? 1'b1 : ($urandom_range(0, 7) == 0);
            step("rand", w, rd, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++)
            step("rand_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // clear and reset with five words held
        for (int i = 0; i < 5; i++)
            step("pre_clr", 1'b1, 64'(400 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_clr_cnt", 64'(count), 64'd5);
        step("mid_clr", 1'b1, 64'h77, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            step("pre_rst", 1'b1, 64'(500 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step("pre_rst2", 1'b1, 64'(600 + i), 1'b0, 1'b0, 1'b0);
        step("mid_rst", 1'b1, 64'h88, 1'b1, 1'b1, 1'b1);
        step("post_rst", 1'b1, 64'h99, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dtpu_out_fifo.md
DTPU_OUT_FIFO -- requirements
Module: dtpu_out_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH_FIFO_OUT, default 64, the data word width.
REQ-002 SHALL have parameter DEPTH, default 16, the storage depth in words; power of two, 2..256.
REQ-003 SHALL have parameter PKT_LEN, default 8, the beats per stream packet; range 1..65535.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port outfifo_write, input, 1 bit: write strobe from dtpu_core.
REQ-007 SHALL have port outfifo_din, input, DATA_WIDTH_FIFO_OUT bits: the word written by dtpu_core.
REQ-008 SHALL have port outfifo_is_full, output, 1 bit: back-pressure to dtpu_core.
REQ-009 SHALL have port clear, input, 1 bit: synchronous flush from the PS.
REQ-010 SHALL have port m_axis_tdata, output, DATA_WIDTH_FIFO_OUT bits: AXI-stream data to the PS.
REQ-011 SHALL have port m_axis_tvalid, output, 1 bit: AXI-stream valid.
REQ-012 SHALL have port m_axis_tready, input, 1 bit: AXI-stream ready.
REQ-013 SHALL have port m_axis_tlast, output, 1 bit: last beat of a packet.
REQ-014 SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag, set on a dropped write.

Function
REQ-016 SHALL be a circular buffer with wr_ptr and rd_ptr of clog2(DEPTH) bits, wrapping from DEPTH-1 to 0, plus an occupancy counter (count).
REQ-017 SHALL accept a write when outfifo_write=1 and outfifo_is_full=0: store outfifo_din at wr_ptr, then increment wr_ptr.
REQ-018 SHALL complete a read when m_axis_tvalid=1 and m_axis_tready=1: increment rd_ptr.
REQ-019 SHALL operate show-ahead: m_axis_tdata = mem[rd_ptr]; m_axis_tvalid = (count != 0).
REQ-020 SHALL give a latency of 1 cycle: a word written at edge N is presented with tvalid=1 after edge N when the buffer was empty.
REQ-021 SHALL drive outfifo_is_full = (count == DEPTH), combinational from registered count.
REQ-022 SHALL drop a write when outfifo_write=1 and outfifo_is_full=1, even if a read completes in the same cycle, and set overflow=1; pointers and data are unchanged.
REQ-023 SHALL update count on a simultaneous accepted write and completed read (including count=1) as follows: count unchanged, both pointers advance, no data corruption.
REQ-024 SHALL hold m_axis_tdata and m_axis_tlast stable while tvalid=1 and tready=0.
REQ-025 SHALL count completed beats in a 16-bit beat counter; m_axis_tlast = tvalid AND (beat_cnt == PKT_LEN-1).
REQ-026 SHALL reset beat_cnt to 0 on the transfer of a tlast beat, otherwise increment it on each transfer; with PKT_LEN=1, tlast is 1 on every valid beat.
REQ-027 SHALL, on clear=1, reset both pointers, count, beat_cnt and overflow to 0 at the next edge; any write or read in that cycle is ignored.
REQ-028 SHALL give reset priority over clear, and clear priority over write and read.
REQ-029 SHALL leave an empty-buffer read attempt (tready=1, tvalid=0) with no effect.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, set wr_ptr=0, rd_ptr=0, count=0, beat_cnt=0 and overflow=0, giving tvalid=0, tlast=0 and outfifo_is_full=0.
REQ-031 SHALL discard stored contents on a reset asserted mid-packet; storage RAM need not be cleared.
REQ-032 SHALL not reset m_axis_tdata, which is don't-care while tvalid=0.

Verification
REQ-033 Single word: after reset, write 64'h2020202020202020 with tready=0 -> next cycle tvalid=1, tdata=64'h2020202020202020, count=1; raise tready -> next cycle tvalid=0, count=0.
REQ-034 Fill/overflow: write 17 words 1..17 with tready=0 -> outfifo_is_full=1 after the 16th, count=16, overflow=1; draining yields exactly 1..16.
REQ-035 Full plus simultaneous read and write: with count=16, tready=1 and write of 64'hAA -> write dropped, count=15, overflow=1.
REQ-036 Packet framing: stream 20 words with tready=1 -> tlast=1 on beats 8 and 16 only; after clear, the next beat is counted as beat 1.
REQ-037 Wrap-around: 40 words with random tready (~50%) and continuous write -> output order equals input order, with no loss while outfifo_is_full is respected.
REQ-038 Clear/reset mid-operation: with count=5, assert clear (or reset) for 1 cycle -> count=0, tvalid=0, overflow=0, outfifo_is_full=0 the next cycle.
